// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
//   Shared types and encodings for the multi-cycle MIPS control FSM:
//   state_t (4-bit FSM state), opcode/funct constants, ALU operation codes,
//   ALU B-operand select codes and pc-source select codes, plus the
//   DECODE-state dispatch helper.
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      ADDIEX = 4'd9,
      ADDIWB = 4'd10,
      JUMP   = 4'd11,
      HALT   = 4'd12
   } state_t;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU operations
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // ALU B-operand select
   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // pc source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // DECODE dispatch: unknown opcodes either park the core in HALT or are
   // skipped like a NOP, depending on halt_illeg.
   function automatic state_t decode_next(input logic [5:0] op, input bit halt_illeg);
      case (op)
         OP_RTYPE:     return EXEC;
         OP_LW, OP_SW: return MEMADR;
         OP_BEQ:       return BRANCH;
         OP_ADDI:      return ADDIEX;
         OP_J:         return JUMP;
         default:      return halt_illeg ? HALT : FETCH;
      endcase
   endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// ---------------------------------------------------------------------------
// mips_alu_dec
//   Combinational ALU-operation decoder for the multi-cycle controller.
//   Ports:
//     state   in  state_t    current controller state
//     funct   in  [OPW-1:0]  IR[5:0], only meaningful in EXEC
//     alu_ctl out [2:0]      ALU operation code
//   Every state that is not EXEC or BRANCH uses add (pc+4, branch target,
//   effective address, addi), so add is the default.
// ---------------------------------------------------------------------------
module mips_alu_dec
   import mips_ctrl_pkg::*;
#(
   parameter int OPW = 6
)(
   input  state_t         state,
   input  logic [OPW-1:0] funct,
   output logic [2:0]     alu_ctl
);

   always_comb begin
      alu_ctl = ALU_ADD;
      case (state)
         EXEC: begin
            case (funct)
               FN_ADD:  alu_ctl = ALU_ADD;
               FN_SUB:  alu_ctl = ALU_SUB;
               FN_AND:  alu_ctl = ALU_AND;
               FN_OR:   alu_ctl = ALU_OR;
               FN_SLT:  alu_ctl = ALU_SLT;
               default: alu_ctl = ALU_ADD;
            endcase
         end
         BRANCH:  alu_ctl = ALU_SUB;
         default: alu_ctl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// ---------------------------------------------------------------------------
// mips_mc_ctrl
//   Multi-cycle control FSM for the MIPS core. Sequences the shared datapath
//   (pc, single memory port, IR, register file, ALU) through FETCH / DECODE /
//   EXEC / MEM / WB steps and stalls on memory wait states.
//   Ports:
//     clk, rst              clock (rising edge), async active-high reset
//     opcode, funct         IR[31:26], IR[5:0]
//     zero                  ALU zero flag (consumed by the datapath pc enable)
//     mem_ready             memory access completes in the cycle it is 1
//     pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
//     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_ctl,
//     pc_source             datapath controls (Moore, mem_ready-gated in
//                           FETCH and MEMWR)
//     retire                one-cycle pulse when an instruction completes
//     halted                set while parked in HALT
// ---------------------------------------------------------------------------
module mips_mc_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int OPW        = 6,
   parameter bit HALT_ILLEG = 1'b1
)(
   input  logic           clk,
   input  logic           rst,
   input  logic [OPW-1:0] opcode,
   input  logic [OPW-1:0] funct,
   input  logic           zero,
   input  logic           mem_ready,
   output logic           pc_write,
   output logic           pc_write_cond,
   output logic           iord,
   output logic           mem_read,
   output logic           mem_write,
   output logic           ir_write,
   output logic           mem_to_reg,
   output logic           reg_dst,
   output logic           reg_write,
   output logic           alu_src_a,
   output logic [1:0]     alu_src_b,
   output logic [2:0]     alu_ctl,
   output logic [1:0]     pc_source,
   output logic           retire,
   output logic           halted
);

   state_t state_q, state_d;

   // The branch decision (pc_write_cond & zero) is made in the datapath;
   // zero is part of this interface only so both sides share one port list.
   logic unused_zero;
   assign unused_zero = zero;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:   state_d = mem_ready ? DECODE : FETCH;
         DECODE:  state_d = decode_next(opcode, HALT_ILLEG);
         MEMADR:  state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
         MEMWB:   state_d = FETCH;
         MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
         EXEC:    state_d = ALUWB;
         ALUWB:   state_d = FETCH;
         BRANCH:  state_d = FETCH;
         ADDIEX:  state_d = ADDIWB;
         ADDIWB:  state_d = FETCH;
         JUMP:    state_d = FETCH;
         HALT:    state_d = HALT;
         // Unused encodings recover to a clean instruction boundary.
         default: state_d = FETCH;
      endcase
   end

   // ------------------------------------------------------------------
   // Output decode
   // ------------------------------------------------------------------
   mips_alu_dec #(
      .OPW     (OPW)
   ) u_alu_dec (
      .state   (state_q),
      .funct   (funct),
      .alu_ctl (alu_ctl)
   );

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      pc_source     = PCSRC_ALU;
      retire        = 1'b0;
      halted        = 1'b0;

      case (state_q)
         FETCH: begin
            // pc+4 is computed every FETCH cycle, but pc and IR only load
            // on the cycle the memory actually returns the instruction.
            mem_read  = 1'b1;
            iord      = 1'b0;
            alu_src_a = 1'b0;
            alu_src_b = SRCB_FOUR;
            pc_source = PCSRC_ALU;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         DECODE: begin
            // Branch target precompute: pc + (imm << 2).
            alu_src_a = 1'b0;
            alu_src_b = SRCB_IMM_SH2;
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            reg_dst    = 1'b0;
            retire     = 1'b1;
         end
         MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            retire    = mem_ready;
         end
         EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_B;
         end
         ALUWB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            mem_to_reg = 1'b0;
            retire     = 1'b1;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_src_b     = SRCB_B;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
            retire        = 1'b1;
         end
         ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         ADDIWB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            retire     = 1'b1;
         end
         JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
            retire    = 1'b1;
         end
         HALT: begin
            halted = 1'b1;
         end
         default: begin
         end
      endcase

      // Architectural state must not change while reset is held, even in
      // the cycle reset rises mid-access (e.g. an aborted store).
      if (rst) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         reg_write = 1'b0;
         mem_write = 1'b0;
         retire    = 1'b0;
      end
   end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
module tb_mips_mc_ctrl;

   // ------------------------------------------------------------------
   // DUT signals
   // ------------------------------------------------------------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = 6'b000000;
   logic [5:0] funct = 6'b100000;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_ctl;
   logic [1:0] pc_source;
   logic       retire, halted;

   mips_mc_ctrl #(
      .OPW           (6),
      .HALT_ILLEG    (1'b1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .opcode        (opcode),
      .funct         (funct),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .iord          (iord),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_ctl       (alu_ctl),
      .pc_source     (pc_source),
      .retire        (retire),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   // Control word, MSB first:
   // 18 pc_write 17 pc_write_cond 16 iord 15 mem_read 14 mem_write 13 ir_write
   // 12 mem_to_reg 11 reg_dst 10 reg_write 9 alu_src_a 8:7 alu_src_b
   // 6:4 alu_ctl 3:2 pc_source 1 retire 0 halted
   logic [18:0] ctrl_word;
   assign ctrl_word = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                       alu_ctl, pc_source, retire, halted};

   typedef enum logic [3:0] {
      E_RESET, E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_MEMWR,
      E_EXEC, E_ALUWB, E_BRANCH, E_ADDIEX, E_ADDIWB, E_JUMP, E_HALT
   } ex_t;

   typedef struct packed {
      ex_t         tag;
      logic [18:0] word;
      logic [18:0] care;
   } ent_t;

   ent_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   n_ret_exp = 0;
   int   n_ret_seen = 0;

   // Hand table of the expected control word per step. Enables, retire and
   // halted are always checked; muxes only where the step defines them.
   function automatic ent_t mk_exp(input ex_t st, input logic mr, input logic [2:0] alu);
      ent_t x;
      x.tag  = st;
      x.word = '0;
      x.care = 19'b11_0_11_1_00_1_0_00_000_00_11;
      case (st)
         E_RESET: x.care = 19'b10_0_01_1_00_1_0_00_000_00_11;
         E_FETCH: begin
            x.word[15] = 1'b1;      x.word[13] = mr;       x.word[18] = mr;
            x.word[8:7] = 2'b01;    x.word[6:4] = 3'b010;  x.word[3:2] = 2'b00;
            x.care[16] = 1'b1;      x.care[9] = 1'b1;      x.care[8:4] = '1;
            x.care[3:2] = '1;
         end
         E_DECODE: begin
            x.word[8:7] = 2'b11;    x.word[6:4] = 3'b010;
            x.care[9:4] = '1;
         end
         E_MEMADR, E_ADDIEX: begin
            x.word[9] = 1'b1;       x.word[8:7] = 2'b10;   x.word[6:4] = 3'b010;
            x.care[9:4] = '1;
         end
         E_MEMRD: begin
            x.word[15] = 1'b1;      x.word[16] = 1'b1;     x.care[16] = 1'b1;
         end
         E_MEMWB: begin
            x.word[10] = 1'b1;      x.word[12] = 1'b1;     x.word[1] = 1'b1;
            x.care[12:11] = '1;
         end
         E_MEMWR: begin
            x.word[14] = 1'b1;      x.word[16] = 1'b1;     x.word[1] = mr;
            x.care[16] = 1'b1;
         end
         E_EXEC: begin
            x.word[9] = 1'b1;       x.word[6:4] = alu;
            x.care[9:4] = '1;
         end
         E_ALUWB: begin
            x.word[10] = 1'b1;      x.word[11] = 1'b1;     x.word[1] = 1'b1;
            x.care[12:11] = '1;
         end
         E_BRANCH: begin
            x.word[9] = 1'b1;       x.word[6:4] = 3'b110;  x.word[17] = 1'b1;
            x.word[3:2] = 2'b01;    x.word[1] = 1'b1;
            x.care[9:2] = '1;
         end
         E_ADDIWB: begin
            x.word[10] = 1'b1;      x.word[1] = 1'b1;      x.care[12:11] = '1;
         end
         E_JUMP: begin
            x.word[18] = 1'b1;      x.word[3:2] = 2'b10;   x.word[1] = 1'b1;
            x.care[3:2] = '1;
         end
         E_HALT: x.word[0] = 1'b1;
         default: ;
      endcase
      return x;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(1, 0));
   endfunction

   // One clock of stimulus: drive inputs after the edge, queue expectation.
   task automatic step(input ex_t st, input logic mr, input logic [2:0] alu, input logic r);
      @(posedge clk);
      #1;
      rst       = r;
      mem_ready = mr;
      sb_q.push_back(mk_exp(st, mr, alu));
   endtask

   task automatic do_fetch(input int waits);
      repeat (waits) step(E_FETCH, 1'b0, 3'b000, 1'b0);
      step(E_FETCH, 1'b1, 3'b000, 1'b0);
   endtask

   task automatic do_r(input logic [5:0] fn, input logic [2:0] alu, input int fw);
      opcode = 6'b000000; funct = fn;
      do_fetch(fw);
      step(E_DECODE, rb(), 3'b000, 1'b0);
      step(E_EXEC,   rb(), alu,    1'b0);
      step(E_ALUWB,  rb(), 3'b000, 1'b0);
      n_ret_exp++;
   endtask

   task automatic do_lw(input int waits, input int fw);
      opcode = 6'b100011; funct = 6'($urandom);
      do_fetch(fw);
      step(E_DECODE, rb(), 3'b000, 1'b0);
      step(E_MEMADR, rb(), 3'b000, 1'b0);
      repeat (waits) step(E_MEMRD, 1'b0, 3'b000, 1'b0);
      step(E_MEMRD, 1'b1, 3'b000, 1'b0);
      step(E_MEMWB, rb(), 3'b000, 1'b0);
      n_ret_exp++;
   endtask

   task automatic do_sw(input int waits, input int fw);
      opcode = 6'b101011; funct = 6'($urandom);
      do_fetch(fw);
      step(E_DECODE, rb(), 3'b000, 1'b0);
      step(E_MEMADR, rb(), 3'b000, 1'b0);
      repeat (waits) step(E_MEMWR, 1'b0, 3'b000, 1'b0);
      step(E_MEMWR, 1'b1, 3'b000, 1'b0);
      n_ret_exp++;
   endtask

   task automatic do_beq(input logic z, input int fw);
      opcode = 6'b000100; zero = z;
      do_fetch(fw);
      step(E_DECODE, rb(), 3'b000, 1'b0);
      step(E_BRANCH, rb(), 3'b000, 1'b0);
      n_ret_exp++;
   endtask

   task automatic do_addi(input int fw);
      opcode = 6'b001000; funct = 6'($urandom);
      do_fetch(fw);
      step(E_DECODE, rb(), 3'b000, 1'b0);
      step(E_ADDIEX, rb(), 3'b000, 1'b0);
      step(E_ADDIWB, rb(), 3'b000, 1'b0);
      n_ret_exp++;
   endtask

   task automatic do_j(input int fw);
      opcode = 6'b000010;
      do_fetch(fw);
      step(E_DECODE, rb(), 3'b000, 1'b0);
      step(E_JUMP,   rb(), 3'b000, 1'b0);
      n_ret_exp++;
   endtask

   // Illegal opcode parks in HALT; a reset cycle brings the core back.
   task automatic do_illegal(input logic [5:0] op, input int cycles);
      opcode = op;
      do_fetch(0);
      step(E_DECODE, rb(), 3'b000, 1'b0);
      repeat (cycles) step(E_HALT, rb(), 3'b000, 1'b0);
      step(E_RESET, 1'b1, 3'b000, 1'b1);
   endtask

   // ------------------------------------------------------------------
   // Monitor / scoreboard
   // ------------------------------------------------------------------
   always @(negedge clk) begin
      ent_t en;
      if (sb_q.size() > 0) begin
         en = sb_q.pop_front();
         n_vec++;
         if ((ctrl_word & en.care) !== (en.word & en.care)) begin
            n_err++;
            $display("FAIL ctrl_%s: got %b required %b (checked bits %b)",
                     en.tag.name(), ctrl_word, en.word, en.care);
         end
      end
      if (!rst) begin
         n_vec++;
         if ((mem_read & mem_write) !== 1'b0) begin
            n_err++;
            $display("FAIL mem_excl: mem_read=%b mem_write=%b required not both 1", mem_read, mem_write);
         end
         n_vec++;
         if ((pc_write & pc_write_cond) !== 1'b0) begin
            n_err++;
            $display("FAIL pc_excl: pc_write=%b pc_write_cond=%b required not both 1", pc_write, pc_write_cond);
         end
      end
      if (retire === 1'b1) begin
         n_ret_seen++;
         $display("retire %0d at %0t: opcode=%b funct=%b alu_ctl=%b", n_ret_seen, $time, opcode, funct, alu_ctl);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      // 1: reset held 2 cycles with mem_ready=1, then an R-type add.
      step(E_RESET, 1'b1, 3'b000, 1'b1);
      step(E_RESET, 1'b1, 3'b000, 1'b1);
      do_r(6'b100000, 3'b010, 0);
      do_r(6'b100010, 3'b110, 0);
      do_r(6'b100100, 3'b000, 1);
      do_r(6'b100101, 3'b001, 0);
      do_r(6'b101010, 3'b111, 0);
      do_r(6'b000111, 3'b010, 0);   // unlisted funct falls back to add

      // 2: lw with 3 wait states in MEMRD.
      do_lw(3, 0);
      do_lw(0, 0);

      // 3: beq taken and not taken.
      do_beq(1'b1, 0);
      do_beq(1'b0, 0);

      do_addi(0);
      do_j(0);
      do_sw(0, 0);
      do_sw(2, 1);

      // 4: illegal opcode -> HALT for 10 cycles, cleared by reset.
      do_illegal(6'b111111, 10);
      do_r(6'b100000, 3'b010, 0);

      // 5: store aborted by reset rising mid-MEMWR.
      opcode = 6'b101011;
      do_fetch(0);
      step(E_DECODE, 1'b1, 3'b000, 1'b0);
      step(E_MEMADR, 1'b1, 3'b000, 1'b0);
      step(E_MEMWR,  1'b0, 3'b000, 1'b0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if ({mem_write, pc_write, ir_write, reg_write, retire} !== 5'b00000) begin
         n_err++;
         $display("FAIL abort_store: {mem_write,pc_write,ir_write,reg_write,retire}=%b required 00000",
                  {mem_write, pc_write, ir_write, reg_write, retire});
      end
      step(E_RESET, 1'b1, 3'b000, 1'b1);
      do_j(0);

      // 6: randomised instruction mix with random wait states.
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(6, 0))
            0: do_r(6'b100010, 3'b110, int'($urandom_range(1, 0)));
            1: do_lw(int'($urandom_range(2, 0)), int'($urandom_range(1, 0)));
            2: do_sw(int'($urandom_range(2, 0)), int'($urandom_range(1, 0)));
            3: do_beq(rb(), int'($urandom_range(1, 0)));
            4: do_addi(int'($urandom_range(1, 0)));
            5: do_j(int'($urandom_range(1, 0)));
            default: do_illegal(6'b000011, 2);
         endcase
      end

      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL sb_drain: %0d entries left, required 0", sb_q.size());
      end
      n_vec++;
      if (n_ret_seen != n_ret_exp) begin
         n_err++;
         $display("FAIL retire_count: got %0d required %0d", n_ret_seen, n_ret_exp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
